jesd204b_link_tx: RTL
=====================

# jesd204b_link_tx

Parametrised JESD204B transmit data link layer controller. It sits between the transport layer output and the per-lane 8B10B encoders, and replaces the fixed start-up delay used in the current loopback top level with real link bring-up. The block runs code group synchronisation (CGS), then the initial lane alignment sequence (ILAS), then scrambled user data with frame/multiframe alignment character insertion. Each lane has its own scrambler, and the lane count is a parameter.

## Interface
- LANES, 4, number of lanes; one octet per lane per clock
- F, 2, octets per frame per lane (1..16)
- K, 32, frames per multiframe; F*K must be ≤ 1024
- ILAS_MF, 4, number of ILAS multiframes (≥ 2)
- SCRAMBLE, 1, 1 = scrambling enabled, 0 = disabled
- SYNC_FILT, 4, consecutive low `sync_n` cycles that trigger a resync
- clock, input, 1, single clock for all logic
- reset, input, 1, synchronous, active-high
- sync_n, input, 1, SYNC~ from the receiver; active-low request for CGS
- tx_data, input, LANES*8, transport-layer octets; lane i uses [i*8+:8]
- ilas_cfg, input, 14*8, link configuration octets 0..13, sent in ILAS multiframe 1
- tx_ready, output, 1, tx_data is consumed this cycle
- lane_data, output, LANES*8, octet per lane to the 8B10B encoder
- lane_k, output, LANES, control-character flag per lane
- link_state, output, 2, 0 = CGS, 1 = ILAS, 2 = DATA
- sync_err_cnt, output, 8, count of short `sync_n` low pulses (saturating)

## Operation
- **LMFC counter:** octet index `oc` runs 0..F*K-1. It is free-running from reset and wraps at F*K-1. End of frame: `oc % F == F-1`. End of multiframe: `oc == F*K-1`.
- **CGS:** all lanes output K28.5 (0xBC, k=1).
  - Transition to ILAS requires `sync_n` sampled high for at least one cycle, followed by an `oc` wrap to 0.
  - ILAS begins on the cycle with `oc == 0`.
- **ILAS:** lasts ILAS_MF multiframes, counted by `mf` (0..ILAS_MF-1). Within each multiframe:
  - oc 0: K28.0 (0x1C, k=1)
  - oc F*K-1: K28.3 (0x7C, k=1)
  - all other oc: the data ramp `oc[7:0]` with k=0
  - In mf 1 only, this overrides the above: oc 1 is K28.4 (0x9C, k=1), and oc 2..15 carry `ilas_cfg` octets 0..13 with k=0.
  - After the last octet of multiframe ILAS_MF-1, the next cycle is DATA.
- **DATA:**
  - `tx_ready` = 1.
  - Lane octet = scrambled `tx_data` when SCRAMBLE = 1, raw `tx_data` otherwise; k=0.
- **Scrambler (per lane):** polynomial 1+x^14+x^15. Octets are processed MSB first, with s[n] = d[n] ^ s[n-14] ^ s[n-15], where the history is the previous *scrambled* bits.
  - The 15-bit state loads 0x7FFF on the ILAS→DATA transition.
  - The state advances on every DATA octet, including octets that are replaced by alignment characters.
- **Character replacement (DATA state):**
  - SCRAMBLE = 1:
    - At end of multiframe, if the pre-scramble octet == 0x7C, output 0x7C with k=1.
    - Else at end of frame, if the pre-scramble octet == 0xFC, output 0xFC with k=1.
  - SCRAMBLE = 0:
    - At end of frame, if the octet equals the same lane's last octet of the previous frame, output 0x7C (k=1) at end of multiframe, otherwise 0xFC (k=1).
    - The comparison always uses the original (unreplaced) octet.
    - The previous-frame register clears to 0x00 on DATA entry.
    - Replacement is never applied to the first frame after DATA entry.
- **Resync:**
  - In ILAS or DATA, `sync_n` low for SYNC_FILT consecutive cycles moves the block to CGS on the next cycle.
  - A low pulse of 1..SYNC_FILT-1 cycles increments `sync_err_cnt` on its rising edge (saturating at 255); the state does not change.
  - In CGS, `sync_n` low is the normal condition and is not counted.
- All lanes always carry the same control characters at the same time.

## Timing
- Reset values:
  - `lane_data` = {LANES{0xBC}}, `lane_k` = all ones, `link_state` = 0, `tx_ready` = 0, `sync_err_cnt` = 0, `oc` = 0, `mf` = 0.
  - Scrambler states = 0x7FFF.
- Outputs are registered. `tx_data` sampled while `tx_ready` = 1 appears on `lane_data` exactly 1 cycle later.
- `tx_ready` rises in the same cycle that `link_state` becomes 2. It falls in the same cycle that `link_state` leaves 2.
- With `sync_n` rising in the cycle with oc = j, the first K28.0 appears on `lane_data` when oc next equals 0.
  - If j = F*K-1, that is the very next wrap.
- `sync_n` going low in the same cycle as the ILAS→DATA transition: the transition still happens, and filter counting starts from that cycle.
- `reset` mid-operation returns everything to reset values on the next edge. The LMFC counter restarts at 0.

## Structure
- Shared package `jesd204b_pkg`:
  - character constants K28_5 = 0xBC, K28_0 = 0x1C, K28_3 = 0x7C, K28_4 = 0x9C, K28_7 = 0xFC
  - link_state encodings
  - scrambler seed 0x7FFF
- One sub-module, `jesd204b_lane_scrambler`: 8-bit per-lane scrambler with `load` and `en` inputs, instantiated LANES times.
- The top level holds the LMFC counter, `mf` counter, state machine, sync filter and replacement muxes.

## Test plan
- **Basic bring-up:** reset, `sync_n` = 0 for 100 cycles → all lanes 0xBC/k=1. Raise `sync_n` at oc = 5 (F=2, K=32) → K28.0 appears at the next oc = 0, and link_state = 1.
- **ILAS contents:** check `ilas_cfg` = 0x01..0x0E →
  - mf 1: oc 1 = 0x9C/k=1 and oc 2..15 = 0x01..0x0E/k=0
  - every multiframe: last octet 0x7C/k=1, ramp values elsewhere
  - DATA begins after 4*64 octets.
- **Scrambled data:** SCRAMBLE = 1, `tx_data` = 0x00 constant → lane output matches a software model seeded 0x7FFF, with k=0. Force a pre-scramble 0xFC at end of frame → 0xFC/k=1.
- **Unscrambled replacement:** SCRAMBLE = 0, constant 0x55 →
  - first frame unreplaced
  - afterwards every end-of-frame = 0xFC/k=1
  - every end-of-multiframe = 0x7C/k=1
  - all other octets 0x55.
- **Sync filter:** `sync_n` low for 3 cycles in DATA → state stays 2 and `sync_err_cnt` = 1. Low for 4 cycles → CGS, 0xBC output and `tx_ready` = 0.
- **Reset mid-ILAS:** assert `reset` for 1 cycle during mf 2 → next cycle all outputs at reset values and link_state = 0.

Source files
------------

// File: rtl/jesd204b_pkg.sv
// Shared constants and types for the JESD204B transmit link layer.
package jesd204b_pkg;

    localparam int unsigned OCT_W = 8;
    localparam int unsigned OC_W  = 10;
    localparam int unsigned FC_W  = 4;

    localparam logic [OCT_W-1:0] K28_5 = 8'hBC;
    localparam logic [OCT_W-1:0] K28_0 = 8'h1C;
    localparam logic [OCT_W-1:0] K28_3 = 8'h7C;
    localparam logic [OCT_W-1:0] K28_4 = 8'h9C;
    localparam logic [OCT_W-1:0] K28_7 = 8'hFC;

    localparam logic [14:0] SCR_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        LS_CGS  = 2'd0,
        LS_ILAS = 2'd1,
        LS_DATA = 2'd2
    } link_state_e;

    typedef struct packed {
        logic             k;
        logic [OCT_W-1:0] d;
    } lane_oct_t;

    function automatic lane_oct_t mk_ctrl(input logic [OCT_W-1:0] c);
        lane_oct_t o;
        o.k = 1'b1;
        o.d = c;
        return o;
    endfunction

    function automatic lane_oct_t mk_data(input logic [OCT_W-1:0] c);
        lane_oct_t o;
        o.k = 1'b0;
        o.d = c;
        return o;
    endfunction

endpackage

// File: rtl/jesd204b_lane_scrambler.sv
// Per-lane self-synchronous scrambler, 1+x^14+x^15, one octet per clock, MSB first.
module jesd204b_lane_scrambler
    import jesd204b_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [OCT_W-1:0] octet,
    output logic [OCT_W-1:0] scrambled_c
);

    logic [14:0] state_q;
    logic [14:0] state_d;

    // Bit 0 holds the newest scrambled bit; a load seeds the octet being scrambled now.
    always_comb begin
        logic [14:0] s;
        logic        b;
        s           = load ? SCR_SEED : state_q;
        b           = 1'b0;
        scrambled_c = '0;
        for (int i = OCT_W - 1; i >= 0; i--) begin
            b              = octet[i] ^ s[13] ^ s[14];
            scrambled_c[i] = b;
            s              = {s[13:0], b};
        end
        state_d = s;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SCR_SEED;
        end else if (en) begin
            state_q <= state_d;
        end else if (load) begin
            state_q <= SCR_SEED;
        end
    end

endmodule

// File: rtl/jesd204b_link_tx.sv
// JESD204B transmit data link layer: CGS, ILAS, then scrambled data with alignment characters.
module jesd204b_link_tx
    import jesd204b_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned F         = 2,
    parameter int unsigned K         = 32,
    parameter int unsigned ILAS_MF   = 4,
    parameter int unsigned SCRAMBLE  = 1,
    parameter int unsigned SYNC_FILT = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sync_n,
    input  logic [LANES*OCT_W-1:0] tx_data,
    input  logic [14*OCT_W-1:0]    ilas_cfg,
    output logic                   tx_ready,
    output logic [LANES*OCT_W-1:0] lane_data,
    output logic [LANES-1:0]       lane_k,
    output logic [1:0]             link_state,
    output logic [7:0]             sync_err_cnt
);

    localparam int unsigned FK    = F * K;
    localparam int unsigned MF_W  = $clog2(ILAS_MF);
    localparam int unsigned FLT_W = $clog2(SYNC_FILT + 1);

    link_state_e             state_q, state_d;
    logic [OC_W-1:0]         oc_q, oc_d;
    logic [FC_W-1:0]         fc_q, fc_d;
    logic [MF_W-1:0]         mf_q, mf_d;
    logic [FLT_W-1:0]        low_cnt_q, low_cnt_d;
    logic                    sync_seen_q, sync_seen_d;
    logic [7:0]              err_d;
    logic                    first_frm_q, first_frm_d;
    logic [LANES*OCT_W-1:0]  prev_q, prev_d;
    logic [LANES*OCT_W-1:0]  lane_data_d;
    logic [LANES-1:0]        lane_k_d;
    logic [LANES*OCT_W-1:0]  scr_c;

    logic eomf_q, resync, enter_data, scr_en, eof_d, eomf_d;

    assign link_state = state_q;
    assign eomf_q     = (oc_q == OC_W'(FK - 1));
    assign resync     = (state_q != LS_CGS) && !sync_n && (low_cnt_q == FLT_W'(SYNC_FILT - 1));
    assign scr_en     = (state_d == LS_DATA);
    assign enter_data = scr_en && (state_q != LS_DATA);
    assign eof_d      = (fc_d == FC_W'(F - 1));
    assign eomf_d     = (oc_d == OC_W'(FK - 1));

    // LMFC counters, sync filter and link state machine.
    always_comb begin
        state_d     = state_q;
        oc_d        = eomf_q ? '0 : oc_q + 1'b1;
        fc_d        = (eomf_q || fc_q == FC_W'(F - 1)) ? '0 : fc_q + 1'b1;
        mf_d        = mf_q;
        low_cnt_d   = '0;
        sync_seen_d = 1'b0;
        err_d       = sync_err_cnt;

        if (state_q == LS_CGS) begin
            sync_seen_d = sync_seen_q | sync_n;
        end else if (!sync_n) begin
            low_cnt_d = (low_cnt_q == FLT_W'(SYNC_FILT)) ? low_cnt_q : low_cnt_q + 1'b1;
        end else if (low_cnt_q != '0 && sync_err_cnt != 8'hFF) begin
            err_d = sync_err_cnt + 8'd1;
        end

        case (state_q)
            LS_CGS: begin
                if ((sync_seen_q || sync_n) && eomf_q) begin
                    state_d = LS_ILAS;
                end
            end
            LS_ILAS: begin
                if (resync) begin
                    state_d = LS_CGS;
                end else if (eomf_q && mf_q == MF_W'(ILAS_MF - 1)) begin
                    state_d = LS_DATA;
                end
            end
            LS_DATA: begin
                if (resync) begin
                    state_d = LS_CGS;
                end
            end
            default: state_d = LS_CGS;
        endcase

        if (state_d != LS_ILAS) begin
            mf_d = '0;
        end else if (state_q == LS_ILAS && eomf_q) begin
            mf_d = mf_q + 1'b1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_scr
        jesd204b_lane_scrambler u_scr (
            .clock       (clock),
            .reset       (reset),
            .load        (enter_data),
            .en          (scr_en),
            .octet       (tx_data[l*OCT_W +: OCT_W]),
            .scrambled_c (scr_c[l*OCT_W +: OCT_W])
        );
    end

    // Octet for the cycle being entered; a data octet is the tx_data captured on that edge.
    always_comb begin
        lane_oct_t       ilas_oct;
        lane_oct_t       oct;
        logic [OCT_W-1:0] raw;
        logic [3:0]      cfg_idx;

        lane_data_d = '0;
        lane_k_d    = '0;
        prev_d      = prev_q;
        first_frm_d = (state_d != LS_DATA) ? 1'b1 : (eof_d ? 1'b0 : first_frm_q);
        cfg_idx     = oc_d[3:0] - 4'd2;

        ilas_oct = mk_data(oc_d[7:0]);
        if (oc_d == '0) begin
            ilas_oct = mk_ctrl(K28_0);
        end else if (eomf_d) begin
            ilas_oct = mk_ctrl(K28_3);
        end
        if (mf_d == MF_W'(1)) begin
            if (oc_d == OC_W'(1)) begin
                ilas_oct = mk_ctrl(K28_4);
            end else if (oc_d >= OC_W'(2) && oc_d <= OC_W'(15)) begin
                ilas_oct = mk_data(ilas_cfg[{cfg_idx, 3'b000} +: OCT_W]);
            end
        end

        for (int l = 0; l < LANES; l++) begin
            raw = tx_data[l*OCT_W +: OCT_W];
            oct = mk_ctrl(K28_5);
            case (state_d)
                LS_ILAS: oct = ilas_oct;
                LS_DATA: begin
                    if (SCRAMBLE != 0) begin
                        oct = mk_data(scr_c[l*OCT_W +: OCT_W]);
                        if (eomf_d && raw == K28_3) begin
                            oct = mk_ctrl(K28_3);
                        end else if (eof_d && raw == K28_7) begin
                            oct = mk_ctrl(K28_7);
                        end
                    end else begin
                        oct = mk_data(raw);
                        if (eof_d && !first_frm_q && raw == prev_q[l*OCT_W +: OCT_W]) begin
                            oct = mk_ctrl(eomf_d ? K28_3 : K28_7);
                        end
                    end
                    if (eof_d) begin
                        prev_d[l*OCT_W +: OCT_W] = raw;
                    end
                end
                default: oct = mk_ctrl(K28_5);
            endcase
            if (state_d != LS_DATA) begin
                prev_d[l*OCT_W +: OCT_W] = '0;
            end
            lane_data_d[l*OCT_W +: OCT_W] = oct.d;
            lane_k_d[l]                   = oct.k;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LS_CGS;
            oc_q         <= '0;
            fc_q         <= '0;
            mf_q         <= '0;
            low_cnt_q    <= '0;
            sync_seen_q  <= 1'b0;
            first_frm_q  <= 1'b1;
            prev_q       <= '0;
            sync_err_cnt <= '0;
            tx_ready     <= 1'b0;
            lane_data    <= {LANES{K28_5}};
            lane_k       <= '1;
        end else begin
            state_q      <= state_d;
            oc_q         <= oc_d;
            fc_q         <= fc_d;
            mf_q         <= mf_d;
            low_cnt_q    <= low_cnt_d;
            sync_seen_q  <= sync_seen_d;
            first_frm_q  <= first_frm_d;
            prev_q       <= prev_d;
            sync_err_cnt <= err_d;
            tx_ready     <= (state_d == LS_DATA);
            lane_data    <= lane_data_d;
            lane_k       <= lane_k_d;
        end
    end

endmodule
